// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control sequencer for a shared-memory datapath (PC, IR, ALU, regfile, one memory port).
// ALUControl: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 pass-B.
module multicycle_control_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32,
  parameter bit RESUME_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             Neg,
  input  logic             Carry,
  input  logic             Ovf,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ImmSrc,
  output logic [3:0]       ALUControl,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXER,
    S_EXEI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_HALT
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             halted_q, halted_d;

  logic       ready;
  logic       pc_we, ir_we, mem_we, reg_we, adr_sel, illegal_c, retire;
  logic [1:0] result_sel, src_a, src_b;
  logic [2:0] imm_sel;
  logic [3:0] alu_ctl;

  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
    logic [3:0] ctl;
    case (f3)
      3'b000:  ctl = alt ? ALU_SUB : ALU_ADD;
      3'b001:  ctl = ALU_SLL;
      3'b010:  ctl = ALU_SLT;
      3'b011:  ctl = ALU_SLTU;
      3'b100:  ctl = ALU_XOR;
      3'b101:  ctl = alt ? ALU_SRA : ALU_SRL;
      3'b110:  ctl = ALU_OR;
      default: ctl = ALU_AND;
    endcase
    return ctl;
  endfunction

  always_comb begin
    state_d    = state_q;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    adr_sel    = 1'b0;
    illegal_c  = 1'b0;
    retire     = 1'b0;
    result_sel = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    imm_sel    = 3'b000;
    alu_ctl    = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        src_b = 2'b10;
        if (ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        src_a   = 2'b01;
        src_b   = 2'b01;
        imm_sel = 3'b010;
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXER;
          7'b0010011:             state_d = S_EXEI;
          7'b1100011:             state_d = S_BRANCH;
          7'b1101111:             state_d = S_JAL;
          7'b1100111:             state_d = S_JALR;
          7'b0110111:             state_d = S_LUI;
          7'b1110011:             state_d = S_HALT;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        imm_sel = op[5] ? 3'b001 : 3'b000;
        state_d = op[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        adr_sel = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_sel = 2'b01;
        reg_we     = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        adr_sel = 1'b1;
        mem_we  = 1'b1;
        if (ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXER: begin
        src_a   = 2'b10;
        alu_ctl = alu_decode(funct3, funct7b5);
        state_d = S_ALUWB;
      end
      S_EXEI: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        // Immediate adds never subtract; funct7b5 only selects srai vs srli.
        alu_ctl = alu_decode(funct3, funct7b5 && (funct3 == 3'b101));
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        src_a   = 2'b10;
        alu_ctl = ALU_SUB;
        case (funct3)
          3'b000:  pc_we = Zero;
          3'b001:  pc_we = ~Zero;
          3'b100:  pc_we = Neg ^ Ovf;
          3'b101:  pc_we = ~(Neg ^ Ovf);
          3'b110:  pc_we = ~Carry;
          3'b111:  pc_we = Carry;
          default: illegal_c = 1'b1;
        endcase
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        pc_we   = 1'b1;
        src_a   = 2'b01;
        src_b   = 2'b10;
        imm_sel = 3'b011;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        pc_we      = 1'b1;
        src_a      = 2'b10;
        src_b      = 2'b01;
        result_sel = 2'b10;
        state_d    = S_ALUWB;
      end
      S_LUI: begin
        src_b   = 2'b01;
        imm_sel = 3'b100;
        alu_ctl = ALU_PASSB;
        state_d = S_ALUWB;
      end
      S_HALT: begin
        if (RESUME_EN && resume) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (reset) begin
      state_d = S_FETCH;
      retire  = 1'b0;
    end
  end

  assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  assign halted_d  = (state_d == S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      halted_q  <= halted_d;
    end
  end

  // Strobes are forced low during the reset cycle whatever state is being left.
  assign PCWrite    = pc_we  & ~reset;
  assign IRWrite    = ir_we  & ~reset;
  assign MemWrite   = mem_we & ~reset;
  assign RegWrite   = reg_we & ~reset;
  assign illegal    = illegal_c & ~reset;
  assign AdrSrc     = adr_sel;
  assign ResultSrc  = result_sel;
  assign ALUSrcA    = src_a;
  assign ALUSrcB    = src_b;
  assign ImmSrc     = imm_sel;
  assign ALUControl = alu_ctl;
  assign halted     = halted_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm; a second instance (2-bit counter, no resume) checks wrap and sticky HALT.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset, funct7b5, Zero, Neg, Carry, Ovf, mem_ready, resume;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, halted, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic [31:0] instret;
  logic       PCWrite2, AdrSrc2, IRWrite2, MemWrite2, RegWrite2, halted2, illegal2;
  logic [1:0] ResultSrc2, ALUSrcA2, ALUSrcB2;
  logic [2:0] ImmSrc2;
  logic [3:0] ALUControl2;
  logic [1:0] instret2;
  logic [3:0] strb;

  int checks = 0;
  int errors = 0;

  assign strb = {PCWrite, IRWrite, MemWrite, RegWrite};

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Neg(Neg), .Carry(Carry), .Ovf(Ovf), .mem_ready(mem_ready), .resume(resume),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .halted(halted), .illegal(illegal), .instret(instret)
  );

  multicycle_control_fsm #(.MEM_HANDSHAKE(1'b1), .CNT_W(2), .RESUME_EN(1'b0)) dut2 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Neg(Neg), .Carry(Carry), .Ovf(Ovf), .mem_ready(mem_ready), .resume(resume),
    .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .IRWrite(IRWrite2), .MemWrite(MemWrite2), .RegWrite(RegWrite2),
    .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ImmSrc(ImmSrc2),
    .ALUControl(ALUControl2), .halted(halted2), .illegal(illegal2), .instret(instret2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; mem_ready = 1'b1; resume = 1'b0;
    tick; tick;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_ready = 1'b1; resume = 1'b0; op = 7'b0110011;
    funct3 = 3'b000; funct7b5 = 1'b0; {Zero, Neg, Carry, Ovf} = 4'b0000;
    tick; tick;
    checks++;
    if (strb !== 4'b0000) begin errors++; $display("FAIL reset_strobes got=%b exp=0000", strb); end
    checks++;
    if (instret !== 32'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL reset_state got instret=%0d halted=%b exp 0/0", instret, halted);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({strb, AdrSrc, ALUSrcA, ALUSrcB, ALUControl} !== {4'b1100, 1'b0, 2'b00, 2'b10, 4'b0000}) begin
      errors++; $display("FAIL fetch_decode got=%b exp=1100_0_00_10_0000",
                         {strb, AdrSrc, ALUSrcA, ALUSrcB, ALUControl});
    end
  endtask

  // op, funct3, funct7b5, expected ALUControl in EXE
  task automatic test_alu;
    logic [6:0] t_op [6] = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011, 7'b0110011, 7'b0010011};
    logic [2:0] t_f3 [6] = '{3'b000, 3'b000, 3'b101, 3'b000, 3'b011, 3'b111};
    logic       t_f7 [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] t_alu[6] = '{4'b0000, 4'b0001, 4'b1001, 4'b0000, 4'b0110, 4'b0010};
    do_reset;
    for (int i = 0; i < 6; i++) begin
      op = t_op[i]; funct3 = t_f3[i]; funct7b5 = t_f7[i];
      checks++;
      if (strb !== 4'b1100) begin errors++; $display("FAIL alu%0d_fetch got=%b exp=1100", i, strb); end
      tick;
      resume = 1'b1;
      checks++;
      if ({strb, ALUSrcA, ALUSrcB, ImmSrc} !== {4'b0000, 2'b01, 2'b01, 3'b010}) begin
        errors++; $display("FAIL alu%0d_decode got=%b exp=0000_01_01_010", i, {strb, ALUSrcA, ALUSrcB, ImmSrc});
      end
      tick;
      resume = 1'b0;
      checks++;
      if ({strb, ALUSrcA, ALUSrcB, ALUControl} !== {4'b0000, 2'b10, t_op[i][5] ? 2'b00 : 2'b01, t_alu[i]}) begin
        errors++; $display("FAIL alu%0d_exe got=%b exp alu=%b", i, {strb, ALUSrcA, ALUSrcB, ALUControl}, t_alu[i]);
      end
      tick;
      checks++;
      if ({strb, ResultSrc} !== {4'b0001, 2'b00} || instret !== 32'(i)) begin
        errors++; $display("FAIL alu%0d_wb got=%b instret=%0d exp=0001_00 instret=%0d", i, {strb, ResultSrc}, instret, i);
      end
      tick;
      checks++;
      if (instret !== 32'(i + 1) || strb !== 4'b1100) begin
        errors++; $display("FAIL alu%0d_retire got instret=%0d strb=%b exp %0d/1100", i, instret, strb, i + 1);
      end
    end
  endtask

  // funct3, {Z,N,C,V}, expected taken, expected illegal
  task automatic test_branch;
    logic [2:0] t_f3 [7] = '{3'b100, 3'b111, 3'b000, 3'b001, 3'b101, 3'b110, 3'b010};
    logic [3:0] t_fl [7] = '{4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0101, 4'b0000, 4'b1000};
    logic       t_tk [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       t_il [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset;
    op = 7'b1100011; funct7b5 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      funct3 = t_f3[i]; {Zero, Neg, Carry, Ovf} = t_fl[i];
      tick; tick;
      checks++;
      if ({strb, ALUSrcA, ALUSrcB, ALUControl, illegal} !== {t_tk[i], 3'b000, 2'b10, 2'b00, 4'b0001, t_il[i]}) begin
        errors++; $display("FAIL branch%0d got=%b exp taken=%b illegal=%b", i,
                           {strb, ALUSrcA, ALUSrcB, ALUControl, illegal}, t_tk[i], t_il[i]);
      end
      tick;
      checks++;
      if (strb !== 4'b1100) begin errors++; $display("FAIL branch%0d_return got=%b exp=1100", i, strb); end
    end
    {Zero, Neg, Carry, Ovf} = 4'b0000;
  endtask

  task automatic test_load;
    do_reset;
    op = 7'b0000011; funct3 = 3'b010;
    tick; tick;
    checks++;
    if ({strb, ALUSrcA, ALUSrcB, ImmSrc} !== {4'b0000, 2'b10, 2'b01, 3'b000}) begin
      errors++; $display("FAIL lw_memadr got=%b exp=0000_10_01_000", {strb, ALUSrcA, ALUSrcB, ImmSrc});
    end
    mem_ready = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({AdrSrc, strb} !== 5'b10000) begin errors++; $display("FAIL lw_wait%0d got=%b exp=10000", i, {AdrSrc, strb}); end
      tick;
    end
    mem_ready = 1'b1;
    checks++;
    if ({AdrSrc, strb} !== 5'b10000) begin errors++; $display("FAIL lw_ready got=%b exp=10000", {AdrSrc, strb}); end
    tick;
    checks++;
    if ({strb, ResultSrc} !== {4'b0001, 2'b01}) begin
      errors++; $display("FAIL lw_memwb got=%b exp=0001_01", {strb, ResultSrc});
    end
    tick;
    checks++;
    if (strb !== 4'b1100 || instret !== 32'd1) begin
      errors++; $display("FAIL lw_retire got strb=%b instret=%0d exp 1100/1", strb, instret);
    end
  endtask

  task automatic test_illegal;
    do_reset;
    op = 7'b0000000;
    tick;
    checks++;
    if ({illegal, strb} !== 5'b10000) begin errors++; $display("FAIL illegal_pulse got=%b exp=10000", {illegal, strb}); end
    tick;
    checks++;
    if ({illegal, strb} !== 5'b01100 || instret !== 32'd0) begin
      errors++; $display("FAIL illegal_return got=%b instret=%0d exp=01100/0", {illegal, strb}, instret);
    end
  endtask

  task automatic test_store_reset;
    do_reset;
    op = 7'b0100011; funct3 = 3'b010;
    tick; tick;
    checks++;
    if (ImmSrc !== 3'b001) begin errors++; $display("FAIL sw_imm got=%b exp=001", ImmSrc); end
    mem_ready = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({AdrSrc, strb} !== 5'b10010) begin errors++; $display("FAIL sw_hold%0d got=%b exp=10010", i, {AdrSrc, strb}); end
      tick;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (strb !== 4'b0000) begin errors++; $display("FAIL sw_reset_cycle got=%b exp=0000", strb); end
    tick;
    reset = 1'b0; mem_ready = 1'b1;
    #1;
    checks++;
    if (strb !== 4'b1100 || instret !== 32'd0) begin
      errors++; $display("FAIL sw_after_reset got strb=%b instret=%0d exp 1100/0", strb, instret);
    end
  endtask

  task automatic test_halt;
    do_reset;
    op = 7'b1110011; funct3 = 3'b000;
    tick;
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL halt_decode got=%b exp=0", halted); end
    tick;
    for (int i = 0; i < 100; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      checks++;
      if ({halted, halted2, strb} !== 6'b110000) begin
        errors++; $display("FAIL halt_hold%0d got=%b exp=110000", i, {halted, halted2, strb});
      end
      tick;
    end
    mem_ready = 1'b0; resume = 1'b1;
    tick;
    resume = 1'b0;
    checks++;
    if ({halted, halted2, instret} !== {2'b01, 32'd0}) begin
      errors++; $display("FAIL halt_resume got halted=%b halted2=%b instret=%0d exp 0/1/0", halted, halted2, instret);
    end
    for (int i = 0; i < 20; i++) begin
      resume = (i == 5);
      tick;
      checks++;
      if ({halted2, strb} !== 5'b10000) begin errors++; $display("FAIL halt_sticky%0d got=%b exp=10000", i, {halted2, strb}); end
    end
    resume = 1'b0;
    do_reset;
    checks++;
    if ({halted, halted2} !== 2'b00) begin errors++; $display("FAIL halt_reset got=%b exp=00", {halted, halted2}); end
  endtask

  task automatic test_wrap;
    logic [1:0] exp2 [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset;
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick; tick; tick; tick;
      checks++;
      if (instret2 !== exp2[i] || instret !== 32'(i + 1)) begin
        errors++; $display("FAIL wrap%0d got instret2=%0d instret=%0d exp %0d/%0d", i, instret2, instret, exp2[i], i + 1);
      end
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_branch;
    test_load;
    test_illegal;
    test_store_reset;
    test_halt;
    test_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
